// File: rtl/barrel_norm_if.sv
`default_nettype none
// barrel_norm_if: start/busy/done handshake and data bundle between a client and barrel_norm.
// Revision 1.0 - initial release.
interface barrel_norm_if #(
  parameter int WIDTH = 16,
  parameter int SW    = 4
);
  logic             start;
  logic             lr;
  logic [WIDTH-1:0] in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] out;
  logic [SW-1:0]    shift;
  logic             zero;

  modport master (
    output start, lr, in,
    input  busy, done, out, shift, zero
  );

  modport slave (
    input  start, lr, in,
    output busy, done, out, shift, zero
  );
endinterface
`default_nettype wire

// File: rtl/barrel_norm.sv
`default_nettype none
// barrel_norm: multi-cycle log search for the leading/trailing-one shift count of a word.
// Revision 1.0 - initial release.
module barrel_norm #(
  parameter int WIDTH = 16,
  parameter int SW    = 4
) (
  input  wire logic    clk,
  input  wire logic    rst,
  barrel_norm_if.slave bus
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [SW-1:0]    k_q, k_d;
  logic [SW-1:0]    cnt_q, cnt_d;
  logic [SW-1:0]    shift_q, shift_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             dir_q, dir_d;
  logic             zero_q, zero_d;
  logic             done_q, done_d;

  // Stage width w = 2^k; rem is WIDTH-w, used to isolate the top or bottom w bits.
  logic [SW:0] step_w;
  logic [SW:0] rem_w;
  logic        hi_zero;
  logic        lo_zero;

  assign step_w  = (SW+1)'(1) << k_q;
  assign rem_w   = (SW+1)'(WIDTH) - step_w;
  assign hi_zero = ((work_q >> rem_w) == '0);
  assign lo_zero = ((work_q << rem_w) == '0);

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    work_d  = work_q;
    out_d   = out_q;
    dir_d   = dir_q;
    zero_d  = zero_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          work_d  = bus.in;
          dir_d   = bus.lr;
          cnt_d   = '0;
          zero_d  = (bus.in == '0);
          k_d     = SW'(SW - 1);
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (dir_q ? hi_zero : lo_zero) begin
          work_d     = dir_q ? (work_q << step_w) : (work_q >> step_w);
          cnt_d[k_q] = 1'b1;
        end else begin
          cnt_d[k_q] = 1'b0;
        end
        if (k_q == '0) begin
          out_d   = work_d;
          shift_d = cnt_d;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          k_d = k_q - SW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      cnt_q   <= '0;
      shift_q <= '0;
      work_q  <= '0;
      out_q   <= '0;
      dir_q   <= 1'b0;
      zero_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      work_q  <= work_d;
      out_q   <= out_d;
      dir_q   <= dir_d;
      zero_q  <= zero_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy  = (state_q == S_RUN);
  assign bus.done  = done_q;
  assign bus.out   = out_q;
  assign bus.shift = shift_q;
  assign bus.zero  = zero_q;

endmodule
`default_nettype wire
